// File: rtl/lora_frame_parser.sv
// LoRa byte-stream frame decoder: header hunt, length/checksum validation,
// display-word update, error counting and inter-byte timeout recovery.
module lora_frame_parser #(
  parameter logic [7:0] HDR0        = 8'hAA,
  parameter logic [7:0] HDR1        = 8'h55,
  parameter logic [7:0] TYPE_DISP   = 8'h01,
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  data_tx,
  input  logic        over_rx,
  output logic [15:0] x,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_H1   = 3'd1;
  localparam logic [2:0] S_TYP  = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
  localparam logic [2:0] S_CSUM = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [7:0]    typ;
  logic [7:0]    len;
  logic [7:0]    sum;
  logic [7:0]    idx;
  logic [7:0]    hi;
  logic [7:0]    lo;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          pass;
  logic          fail;

  // A byte in the same cycle always beats the timeout.
  assign timeout = (state != S_IDLE) && !over_rx && (tcnt == T_LAST);
  assign busy    = (state != S_IDLE);

  // Next-state decode plus accept/reject decisions.
  always_comb begin
    state_nx = state;
    pass     = 1'b0;
    fail     = 1'b0;
    if (over_rx) begin
      unique case (state)
        S_IDLE: begin
          if (data_tx == HDR0) state_nx = S_H1;
        end
        S_H1: begin
          if (data_tx == HDR1)
            state_nx = S_TYP;
          else if (data_tx != HDR0)
            state_nx = S_IDLE;
        end
        S_TYP: state_nx = S_LEN;
        S_LEN: begin
          if (data_tx == 8'd0 || data_tx > MAX_L) begin
            state_nx = S_IDLE;
            fail     = 1'b1;
          end else begin
            state_nx = S_PAY;
          end
        end
        S_PAY: begin
          if (idx == len - 8'd1) state_nx = S_CSUM;
        end
        S_CSUM: begin
          state_nx = S_IDLE;
          if (data_tx == sum)
            pass = 1'b1;
          else
            fail = 1'b1;
        end
        default: state_nx = S_IDLE;
      endcase
    end else if (timeout) begin
      state_nx = S_IDLE;
      fail     = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Inter-byte idle counter, only running inside a frame.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      tcnt <= '0;
    else if (over_rx || state == S_IDLE)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  // Field capture and running checksum.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      typ <= 8'd0;
      len <= 8'd0;
      sum <= 8'd0;
      idx <= 8'd0;
      hi  <= 8'd0;
      lo  <= 8'd0;
    end else if (over_rx) begin
      unique case (state)
        S_TYP: begin
          typ <= data_tx;
          sum <= data_tx;
        end
        S_LEN: begin
          len <= data_tx;
          sum <= sum + data_tx;
          idx <= 8'd0;
        end
        S_PAY: begin
          if (idx == 8'd0) hi <= data_tx;
          if (idx == 8'd1) lo <= data_tx;
          sum <= sum + data_tx;
          idx <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Result pulses, saturating error count and display word.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 8'd0;
      x         <= 16'h0000;
    end else begin
      frame_ok  <= pass;
      frame_err <= fail;
      if (fail && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (pass && typ == TYPE_DISP && len >= 8'd2)
        x <= {hi, lo};
    end
  end

endmodule
